// File: rtl/step_dir_sequencer_pkg.sv
// Shared types and helpers for the step/dir motion command sequencer.
package step_dir_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIR_SETUP,
    ST_STEP_HIGH,
    ST_STEP_LOW
  } seq_state_e;

  // Rise-to-rise spacing must leave at least one low cycle after the pulse.
  function automatic logic [31:0] clamp_period(input logic [31:0] period,
                                               input logic [31:0] min_period);
    return (period < min_period) ? min_period : period;
  endfunction

endpackage

// File: rtl/step_dir_cmd_fifo.sv
// Two-entry command buffer with push/pop/flush; entry0 is always the head.
module step_dir_cmd_fifo #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = entry0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else if (do_push && !do_pop) begin
      count <= count + 2'd1;
    end else if (do_pop && !do_push) begin
      count <= count - 2'd1;
    end
  end

  // With one entry held, a simultaneous push lands directly in the head slot.
  always_ff @(posedge clk) begin
    if (do_pop) begin
      entry0 <= (do_push && count == 2'd1) ? push_data : entry1;
    end else if (do_push && count == 2'd0) begin
      entry0 <= push_data;
    end else if (do_push && count == 2'd1) begin
      entry1 <= push_data;
    end
  end

endmodule

// File: rtl/step_dir_sequencer.sv
// Motion command sequencer: buffers move commands and drives step/dir with
// fixed pulse width, dir setup time and a wrapping signed position count.
module step_dir_sequencer
  import step_dir_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned POS_W            = 32,
  parameter int unsigned STEP_HIGH_CYCLES = 4,
  parameter int unsigned DIR_SETUP_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [CNT_W-1:0] cmd_period,
  input  logic             abort,
  input  logic             pos_load,
  input  logic [POS_W-1:0] pos_value,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic [POS_W-1:0] position
);

  localparam int unsigned CMD_W      = 1 + 2 * CNT_W;
  localparam logic [31:0] MIN_PERIOD = 32'(STEP_HIGH_CYCLES + 1);

  seq_state_e       state;
  seq_state_e       next_state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] period_q;
  logic             abort_q;
  logic             abort_active;

  logic [CMD_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             load_cmd;
  logic             rise;
  logic             timer_zero;

  logic             head_dir;
  logic [CNT_W-1:0] head_steps;
  logic [CNT_W-1:0] head_period;
  logic [CNT_W-1:0] head_eff;
  logic [POS_W-1:0] step_delta;

  assign {head_dir, head_steps, head_period} = fifo_head;
  assign head_eff     = CNT_W'(clamp_period(32'(head_period), MIN_PERIOD));
  assign abort_active = abort || abort_q;
  assign cmd_ready    = !fifo_full && !abort_active;
  assign busy         = (state != ST_IDLE) || !fifo_empty;
  assign timer_zero   = (timer == '0);
  assign rise         = (next_state == ST_STEP_HIGH) && (state != ST_STEP_HIGH);
  assign step_delta   = dir ? POS_W'(1) : '1;

  step_dir_cmd_fifo #(
    .WIDTH(CMD_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (cmd_valid && cmd_ready),
    .push_data({cmd_dir, cmd_steps, cmd_period}),
    .pop      (pop),
    .flush    (abort),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load_cmd   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!abort_active && !fifo_empty) begin
          pop      = 1'b1;
          load_cmd = 1'b1;
        end
      end
      ST_DIR_SETUP: begin
        if (abort_active)    next_state = ST_IDLE;
        else if (timer_zero) next_state = ST_STEP_HIGH;
      end
      ST_STEP_HIGH: begin
        if (timer_zero) next_state = abort_active ? ST_IDLE : ST_STEP_LOW;
      end
      ST_STEP_LOW: begin
        if (abort_active) begin
          next_state = ST_IDLE;
        end else if (timer_zero) begin
          if (remaining != '0) begin
            next_state = ST_STEP_HIGH;
          end else if (!fifo_empty) begin
            pop      = 1'b1;
            load_cmd = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
    // A popped command picks its first state the same way from IDLE or STEP_LOW.
    if (load_cmd) begin
      if (head_steps == '0)     next_state = ST_IDLE;
      else if (head_dir == dir) next_state = ST_STEP_HIGH;
      else                      next_state = ST_DIR_SETUP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      step      <= 1'b0;
      dir       <= 1'b1;
      position  <= '0;
      abort_q   <= 1'b0;
      timer     <= '0;
      remaining <= '0;
      period_q  <= '0;
    end else begin
      state   <= next_state;
      step    <= (next_state == ST_STEP_HIGH);
      abort_q <= abort_active && (next_state != ST_IDLE);

      if (next_state != state) begin
        unique case (next_state)
          ST_DIR_SETUP: timer <= CNT_W'(DIR_SETUP_CYCLES - 1);
          ST_STEP_HIGH: timer <= CNT_W'(STEP_HIGH_CYCLES - 1);
          ST_STEP_LOW:  timer <= period_q - CNT_W'(STEP_HIGH_CYCLES + 1);
          default:      timer <= '0;
        endcase
      end else if (!timer_zero) begin
        timer <= timer - CNT_W'(1);
      end

      if (load_cmd) begin
        period_q  <= head_eff;
        remaining <= head_steps - ((next_state == ST_STEP_HIGH) ? CNT_W'(1) : '0);
        if (head_steps != '0) dir <= head_dir;
      end else if (rise) begin
        remaining <= remaining - CNT_W'(1);
      end

      if (pos_load) begin
        position <= pos_value + (rise ? step_delta : '0);
      end else if (rise) begin
        position <= position + step_delta;
      end
    end
  end

endmodule
